// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - in-order pipeline hazard sequencer: freeze, redirect, load-use stall, forwarding select
module hazard_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_wb,
    input  logic             id_load,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ACT_ADVANCE  = 2'd0;
    localparam logic [1:0] ACT_FREEZE   = 2'd1;
    localparam logic [1:0] ACT_REDIRECT = 2'd2;
    localparam logic [1:0] ACT_LOAD_USE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Tracking pipe: EX keeps everything, MEM/WB keep only what forwarding needs.
    logic       ex_valid;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic       ex_use_rs1;
    logic       ex_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_wb;
    logic       ex_load;
    logic       mem_valid;
    logic [4:0] mem_rd;
    logic       mem_wb;
    logic       mem_load;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_wb;

    logic       load_use;
    logic [1:0] action;
    logic       mem_fwd_ok;
    logic       wb_fwd_ok;

    assign load_use = ex_valid && ex_load && ex_wb && (ex_rd != 5'd0) && id_valid &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        action = ACT_ADVANCE;
        if (mem_busy) begin
            action = ACT_FREEZE;
        end else if (ex_redirect && ex_valid) begin
            action = ACT_REDIRECT;
        end else if (load_use) begin
            action = ACT_LOAD_USE;
        end
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst_n) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (action)
                ACT_FREEZE: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                end
                ACT_REDIRECT: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                ACT_LOAD_USE: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A load in MEM has no result yet, so only ALU producers forward from EX/MEM.
    assign mem_fwd_ok = mem_valid && mem_wb && !mem_load && (mem_rd != 5'd0);
    assign wb_fwd_ok  = wb_valid && wb_wb && (wb_rd != 5'd0);

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (rst_n && ex_valid) begin
            if (mem_fwd_ok && ex_use_rs1 && (mem_rd == ex_rs1)) begin
                fwd_a = 2'b01;
            end else if (wb_fwd_ok && (wb_rd == ex_rs1)) begin
                fwd_a = 2'b10;
            end
            if (mem_fwd_ok && ex_use_rs2 && (mem_rd == ex_rs2)) begin
                fwd_b = 2'b01;
            end else if (wb_fwd_ok && (wb_rd == ex_rs2)) begin
                fwd_b = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_rs1     <= 5'd0;
            ex_rs2     <= 5'd0;
            ex_use_rs1 <= 1'b0;
            ex_use_rs2 <= 1'b0;
            ex_rd      <= 5'd0;
            ex_wb      <= 1'b0;
            ex_load    <= 1'b0;
            mem_valid  <= 1'b0;
            mem_rd     <= 5'd0;
            mem_wb     <= 1'b0;
            mem_load   <= 1'b0;
            wb_valid   <= 1'b0;
            wb_rd      <= 5'd0;
            wb_wb      <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else if (action == ACT_FREEZE) begin
            if (stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end else begin
            wb_valid   <= mem_valid;
            wb_rd      <= mem_rd;
            wb_wb      <= mem_wb;
            mem_valid  <= ex_valid;
            mem_rd     <= ex_rd;
            mem_wb     <= ex_wb;
            mem_load   <= ex_load;
            // Redirect and load-use both inject a bubble into EX.
            ex_valid   <= (action == ACT_ADVANCE) ? id_valid : 1'b0;
            ex_rs1     <= id_rs1;
            ex_rs2     <= id_rs2;
            ex_use_rs1 <= id_use_rs1;
            ex_use_rs2 <= id_use_rs2;
            ex_rd      <= id_rd;
            ex_wb      <= id_wb;
            ex_load    <= id_load;
            if ((action == ACT_LOAD_USE) && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if ((action == ACT_REDIRECT) && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule
